// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: round-robin arbiter sharing the HyperRAM controller's s0 port
// between a CPU master (m0) and a DMA master (m1). Each transaction is serialised,
// address/data are held for the whole burst, and the read/write strobes are separated
// by an idle gap so the controller's edge detector sees a clean rising edge.
// Optional feature: define ARB_TIMEOUT_EN to add a read-abort timeout and the
// sticky timeout_err output.

module hyperram_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WR_DONE_CYCLES = 24,
    parameter int GAP_CYCLES     = 3,
    parameter int RD_TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic              grant,
`ifdef ARB_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              busy
);

    // Counter widths follow the cycle counts they measure; terminal value is count-1.
    localparam int WR_CNT_W  = (WR_DONE_CYCLES > 1) ? $clog2(WR_DONE_CYCLES) : 1;
    localparam int GAP_CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WR_CNT_W-1:0]  WR_LAST  = WR_CNT_W'(WR_DONE_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);
`ifdef ARB_TIMEOUT_EN
    localparam int RD_CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [RD_CNT_W-1:0] RD_LAST      = RD_CNT_W'(RD_TIMEOUT - 1);
    localparam logic [DATA_W-1:0]   TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);
`endif

    // Zero-length phases would make the terminal counts meaningless.
    if (WR_DONE_CYCLES < 1 || GAP_CYCLES < 1 || RD_TIMEOUT < 1) begin : gParamCheck
        $error("hyperram_arbiter: WR_DONE_CYCLES, GAP_CYCLES and RD_TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [WR_CNT_W-1:0] wrCnt_q, wrCnt_d;
    logic [GAP_CNT_W-1:0] gapCnt_q, gapCnt_d;
    logic [ADDR_W-1:0]   sAddress_q, sAddress_d;
    logic [DATA_W-1:0]   sWritedata_q, sWritedata_d;
    logic                sRead_q, sRead_d;
    logic                sWrite_q, sWrite_d;
    logic                grant_q, grant_d;
    logic                m0Wait_q, m0Wait_d;
    logic                m1Wait_q, m1Wait_d;
    logic [DATA_W-1:0]   m0Rdata_q, m0Rdata_d;
    logic [DATA_W-1:0]   m1Rdata_q, m1Rdata_d;
    logic                m0Rdv_q, m0Rdv_d;
    logic                m1Rdv_q, m1Rdv_d;
`ifdef ARB_TIMEOUT_EN
    logic [RD_CNT_W-1:0] rdCnt_q, rdCnt_d;
    logic                timeoutErr_q, timeoutErr_d;
`endif

    logic m0Pending;
    logic m1Pending;
    logic selM1;
    logic selRead;

    // With both pending, the master that did not own the last transaction wins;
    // a simultaneous read+write is served as a read.
    assign m0Pending = m0_read | m0_write;
    assign m1Pending = m1_read | m1_write;
    assign selM1     = (m0Pending && m1Pending) ? ~grant_q : m1Pending;
    assign selRead   = selM1 ? m1_read : m0_read;

    // Next-state and registered-output logic; strobes default to idle each cycle.
    always_comb begin
        state_d      = state_q;
        wrCnt_d      = wrCnt_q;
        gapCnt_d     = gapCnt_q;
        sAddress_d   = sAddress_q;
        sWritedata_d = sWritedata_q;
        sRead_d      = sRead_q;
        sWrite_d     = sWrite_q;
        grant_d      = grant_q;
        m0Wait_d     = 1'b1;
        m1Wait_d     = 1'b1;
        m0Rdata_d    = m0Rdata_q;
        m1Rdata_d    = m1Rdata_q;
        m0Rdv_d      = 1'b0;
        m1Rdv_d      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        rdCnt_d      = rdCnt_q;
        timeoutErr_d = timeoutErr_q;
`endif

        case (state_q)
            IDLE: begin
                if (m0Pending || m1Pending) begin
                    grant_d      = selM1;
                    sAddress_d   = selM1 ? m1_address : m0_address;
                    sWritedata_d = selM1 ? m1_writedata : m0_writedata;
                    if (selM1) begin
                        m1Wait_d = 1'b0;
                    end else begin
                        m0Wait_d = 1'b0;
                    end
                    if (selRead) begin
                        sRead_d = 1'b1;
                        state_d = RD;
`ifdef ARB_TIMEOUT_EN
                        rdCnt_d = '0;
`endif
                    end else begin
                        sWrite_d = 1'b1;
                        wrCnt_d  = '0;
                        state_d  = WR;
                    end
                end
            end

            RD: begin
                if (s_readdatavalid) begin
                    if (grant_q) begin
                        m1Rdata_d = s_readdata;
                        m1Rdv_d   = 1'b1;
                    end else begin
                        m0Rdata_d = s_readdata;
                        m0Rdv_d   = 1'b1;
                    end
                    sRead_d  = 1'b0;
                    gapCnt_d = '0;
                    state_d  = GAP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (rdCnt_q == RD_LAST) begin
                    if (grant_q) begin
                        m1Rdata_d = TIMEOUT_DATA;
                        m1Rdv_d   = 1'b1;
                    end else begin
                        m0Rdata_d = TIMEOUT_DATA;
                        m0Rdv_d   = 1'b1;
                    end
                    timeoutErr_d = 1'b1;
                    sRead_d      = 1'b0;
                    gapCnt_d     = '0;
                    state_d      = GAP;
                end else begin
                    rdCnt_d = rdCnt_q + RD_CNT_W'(1);
                end
`endif
            end

            WR: begin
                if (wrCnt_q == WR_LAST) begin
                    sWrite_d = 1'b0;
                    gapCnt_d = '0;
                    state_d  = GAP;
                end else begin
                    wrCnt_d = wrCnt_q + WR_CNT_W'(1);
                end
            end

            GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + GAP_CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset parks everything idle with m0 favoured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wrCnt_q      <= '0;
            gapCnt_q     <= '0;
            sAddress_q   <= '0;
            sWritedata_q <= '0;
            sRead_q      <= 1'b0;
            sWrite_q     <= 1'b0;
            grant_q      <= 1'b1;
            m0Wait_q     <= 1'b1;
            m1Wait_q     <= 1'b1;
            m0Rdata_q    <= '0;
            m1Rdata_q    <= '0;
            m0Rdv_q      <= 1'b0;
            m1Rdv_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            rdCnt_q      <= '0;
            timeoutErr_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wrCnt_q      <= wrCnt_d;
            gapCnt_q     <= gapCnt_d;
            sAddress_q   <= sAddress_d;
            sWritedata_q <= sWritedata_d;
            sRead_q      <= sRead_d;
            sWrite_q     <= sWrite_d;
            grant_q      <= grant_d;
            m0Wait_q     <= m0Wait_d;
            m1Wait_q     <= m1Wait_d;
            m0Rdata_q    <= m0Rdata_d;
            m1Rdata_q    <= m1Rdata_d;
            m0Rdv_q      <= m0Rdv_d;
            m1Rdv_q      <= m1Rdv_d;
`ifdef ARB_TIMEOUT_EN
            rdCnt_q      <= rdCnt_d;
            timeoutErr_q <= timeoutErr_d;
`endif
        end
    end

    assign m0_waitrequest   = m0Wait_q;
    assign m1_waitrequest   = m1Wait_q;
    assign m0_readdata      = m0Rdata_q;
    assign m1_readdata      = m1Rdata_q;
    assign m0_readdatavalid = m0Rdv_q;
    assign m1_readdatavalid = m1Rdv_q;
    assign s_address        = sAddress_q;
    assign s_writedata      = sWritedata_q;
    assign s_read           = sRead_q;
    assign s_write          = sWrite_q;
    assign grant            = grant_q;
    assign busy             = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
    assign timeout_err      = timeoutErr_q;
`endif

endmodule
